// File: rtl/fp16_acc_seq.sv
// Streaming FP16 accumulator sequencer: feeds an external combinational FP16 adder
// with {running sum, new operand}, registers its result and reports sum/count/overflow.
module fp16_acc_seq #(
    parameter int          CNT_W   = 8,
    parameter logic [15:0] OVF_PAT = 16'hFFFF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_data_i,
    input  logic             in_last_i,
    output logic [15:0]      add_a_o,
    output logic [15:0]      add_b_o,
    input  logic [15:0]      add_sum_i,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic [15:0]      sum_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             xfer;

    // Valid/ready: a beat moves on a cycle where valid and ready are both high;
    // the producer holds its payload steady until that cycle, ready never waits on valid.
    assign in_ready_o  = !rst_i && (state_q != S_DONE);
    assign sum_valid_o = (state_q == S_DONE);
    assign accept      = in_valid_i && in_ready_o;
    assign xfer        = sum_valid_o && sum_ready_i;

    assign add_a_o     = acc_q;
    assign add_b_o     = in_data_i;
    assign sum_o       = acc_q;
    assign cnt_o       = cnt_q;
    assign ovf_o       = ovf_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // First operand loads directly; the adder is not asked to add zero.
                    acc_d   = in_data_i;
                    cnt_d   = CNT_ONE;
                    ovf_d   = 1'b0;
                    state_d = (in_last_i || (CNT_ONE == CNT_MAX)) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!ovf_q) begin
                        acc_d = add_sum_i;
                        ovf_d = (add_sum_i == OVF_PAT);
                    end else begin
                        // Once overflowed the sum stays saturated for the rest of the burst.
                        acc_d = OVF_PAT;
                    end
                    state_d = (in_last_i || (cnt_d == CNT_MAX)) ? S_DONE : S_ACC;
                end
            end
            S_DONE: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    acc_d   = 16'h0000;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fp16_acc_seq.sv
// Directed bench for fp16_acc_seq with a lookup-table adder model; CNT_W=3 so the
// forced-termination limit (7 operands) is reachable in a short run.
module tb_fp16_acc_seq;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_sum;
    logic             sum_valid;
    logic             sum_ready;
    logic [15:0]      sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    fp16_acc_seq #(.CNT_W(CNT_W), .OVF_PAT(16'hFFFF)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_sum_i   (add_sum),
        .sum_valid_o (sum_valid),
        .sum_ready_i (sum_ready),
        .sum_o       (sum),
        .cnt_o       (cnt),
        .ovf_o       (ovf),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: only the sums this bench needs; anything else yields a marker value.
    function automatic logic [15:0] add_model(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] key;
        key = {a, b};
        case (key)
            {16'h3C00, 16'h3C00}: return 16'h4000;
            {16'h4000, 16'h3C00}: return 16'h4200;
            {16'h3C00, 16'h4000}: return 16'h4200;
            {16'h4000, 16'h4000}: return 16'h4400;
            {16'h4200, 16'h3C00}: return 16'h4400;
            {16'h4400, 16'h3C00}: return 16'h4500;
            {16'h4500, 16'h3C00}: return 16'h4600;
            {16'h4600, 16'h3C00}: return 16'h4700;
            {16'h7BFF, 16'h7BFF}: return 16'hFFFF;
            default:              return 16'h1234;
        endcase
    endfunction

    always_comb add_sum = add_model(add_a, add_b);

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0]      ops[4];
        int               n;
        logic [15:0]      exp_sum;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic set_vec(input int idx, input logic [15:0] o0, input logic [15:0] o1,
                           input logic [15:0] o2, input logic [15:0] o3, input int n,
                           input logic [15:0] s, input logic [CNT_W-1:0] c, input logic o);
        vecs[idx].ops[0]  = o0;
        vecs[idx].ops[1]  = o1;
        vecs[idx].ops[2]  = o2;
        vecs[idx].ops[3]  = o3;
        vecs[idx].n       = n;
        vecs[idx].exp_sum = s;
        vecs[idx].exp_cnt = c;
        vecs[idx].exp_ovf = o;
    endtask

    task automatic release_result(input logic exp_ovf);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        check("post_xfer_valid", sum_valid, 1'b0);
        check("post_xfer_ready", in_ready, 1'b1);
        check("post_xfer_sum", sum, 16'h0000);
        check("post_xfer_cnt", cnt, 0);
        check("post_xfer_ovf_sticky", ovf, exp_ovf);
    endtask

    task automatic run_vec(input int idx);
        for (int i = 0; i < vecs[idx].n; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[idx].ops[i];
            in_last  = (i == vecs[idx].n - 1);
            check("burst_in_ready", in_ready, 1'b1);
            check("burst_add_b", add_b, vecs[idx].ops[i]);
            check("burst_no_early_valid", sum_valid, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("vec_sum_valid", sum_valid, 1'b1);
        check("vec_sum", sum, vecs[idx].exp_sum);
        check("vec_cnt", cnt, vecs[idx].exp_cnt);
        check("vec_ovf", ovf, vecs[idx].exp_ovf);
        check("vec_in_ready_done", in_ready, 1'b0);
        release_result(vecs[idx].exp_ovf);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        sum_ready = 1'b0;

        set_vec(0, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 1, 16'h3C00, 3'd1, 1'b0);
        set_vec(1, 16'h3C00, 16'h3C00, 16'h4000, 16'h0000, 3, 16'h4400, 3'd3, 1'b0);
        set_vec(2, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000, 2, 16'hFFFF, 3'd2, 1'b1);
        set_vec(3, 16'h7BFF, 16'h7BFF, 16'h3C00, 16'h0000, 3, 16'hFFFF, 3'd3, 1'b1);
        set_vec(4, 16'h4000, 16'h3C00, 16'h0000, 16'h0000, 2, 16'h4200, 3'd2, 1'b0);

        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_sum_valid", sum_valid, 1'b0);
        check("idle_sum", sum, 16'h0000);
        check("idle_cnt", cnt, 0);
        check("idle_ovf", ovf, 1'b0);
        check("idle_state", dbg_state, 2'd0);

        for (int v = 0; v < 5; v++) run_vec(v);

        // Result held off for 3 cycles: outputs frozen, new operands refused.
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 16'h3C00; tick();
        in_data  = 16'h3C00; tick();
        in_data  = 16'h4000; in_last = 1'b1; tick();
        in_data  = 16'h3C00; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", sum_valid, 1'b1);
            check("stall_sum", sum, 16'h4400);
            check("stall_cnt", cnt, 3);
            check("stall_ovf", ovf, 1'b0);
            check("stall_in_ready", in_ready, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_result(1'b0);

        // Forced termination at 7 operands; the 8th starts a fresh burst.
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        in_last  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("force_in_ready", in_ready, 1'b1);
            tick();
        end
        in_last = 1'b1;
        check("force_valid", sum_valid, 1'b1);
        check("force_sum", sum, 16'h4700);
        check("force_cnt", cnt, 7);
        check("force_in_ready_done", in_ready, 1'b0);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        check("force_idle_ready", in_ready, 1'b1);
        check("force_idle_valid", sum_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("eighth_valid", sum_valid, 1'b1);
        check("eighth_sum", sum, 16'h3C00);
        check("eighth_cnt", cnt, 1);
        release_result(1'b0);

        // Reset mid-burst discards the partial sum.
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        in_last  = 1'b0;
        tick();
        tick();
        check("partial_cnt", cnt, 2);
        check("partial_acc", add_a, 16'h4000);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_cnt", cnt, 0);
        check("midrst_sum", sum, 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_valid", sum_valid, 1'b0);
        end
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("after_rst_valid", sum_valid, 1'b1);
        check("after_rst_sum", sum, 16'h4000);
        check("after_rst_cnt", cnt, 1);
        release_result(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
